// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver (8N1) feeding a byte FIFO, with
// frame-error pulse and sticky overflow / end-of-transmission flags.
// Ports: clk, rst (sync, active-high); urx serial in, idle high;
// rd_valid/rd_ready/rd_data FIFO read side; frame_err one-cycle pulse;
// overflow and eot_seen sticky flags.
// Define UART_RX_MONITOR_PRINT_EN to echo each received byte and each
// frame-error / overflow event on the simulator console.
module uart_rx_monitor #(
  parameter int          CLOCK_FREQ_MHZ = 25,
  parameter int          BAUD_RATE      = 115_200,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [7:0]  EOT_BYTE       = 8'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       urx,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       frame_err,
  output logic       overflow,
  output logic       eot_seen
);

  localparam int CPB = (CLOCK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  logic          s1_q;
  logic          s2_q;
  logic          prev_q;
  logic [1:0]    warm_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          frame_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] wp_d;
  logic [PW-1:0] rp_q;
  logic [PW-1:0] rp_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          eot_q;
  logic          eot_d;

  logic          fall;
  logic          tick;
  logic          push;
  logic          pop;
  logic          wr;
  logic          empty;
  logic          full;

  // The synchronizer resets to 1, so its first outputs after reset are
  // not the real line; warm_q blocks edge detection until prev_q and
  // s2_q both carry sampled values, so a line held low across reset
  // release is not taken as a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      warm_q <= 2'd0;
    end else begin
      s1_q   <= urx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  assign fall = (warm_q == 2'd3) && prev_q && !s2_q;
  // cnt_q holds the cycles left to the next sample point.
  assign tick = (cnt_q == CW'(1));
  assign push = (state_q == STOP) && tick && s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= CW'(CPB / 2);
          end
        end
        START: begin
          if (tick) begin
            if (!s2_q) begin
              state_q <= DATA;
              cnt_q   <= CW'(CPB);
              bit_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            shreg_q <= {s2_q, shreg_q[7:1]};
            cnt_q   <= CW'(CPB);
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        STOP: begin
          if (tick) begin
            if (s2_q) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (s2_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && rd_ready;
  // A full FIFO still takes the byte when the head leaves this cycle.
  assign wr    = push && (!full || pop);

  always_comb begin
    wp_d  = wp_q + PW'(wr);
    rp_d  = rp_q + PW'(pop);
    ovf_d = ovf_q | (push && full && !pop);
    eot_d = eot_q | (push && (shreg_q == EOT_BYTE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      eot_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      eot_q <= eot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wp_q[AW-1:0]] <= shreg_q;
    end
  end

  assign rd_valid  = !empty;
  assign rd_data   = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign frame_err = frame_err_q;
  assign overflow  = ovf_q;
  assign eot_seen  = eot_q;

`ifdef UART_RX_MONITOR_PRINT_EN
  always @(posedge clk) begin
    if (!rst && push) begin
      $write("%c", shreg_q);
    end
    if (!rst && push && full && !pop) begin
      $display("uart_rx_monitor: overflow, byte %02h dropped", shreg_q);
    end
    if (!rst && (state_q == STOP) && tick && !s2_q) begin
      $display("uart_rx_monitor: frame error (stop bit low)");
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: scenario tasks against a queue-based model
// of the UART receiver and its byte FIFO.
module tb_uart_rx_monitor;

  localparam int CPB     = (25 * 1_000_000) / 115_200;
  localparam int LAT_MIN = (19 * CPB) / 2;
  localparam int LAT_MAX = LAT_MIN + 7;
  localparam logic [7:0] EOT = 8'h04;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       urx = 1'b1;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overflow;
  logic       eot_seen;

  always #20 clk = ~clk;

  uart_rx_monitor #(
    .CLOCK_FREQ_MHZ(25),
    .BAUD_RATE(115_200),
    .FIFO_DEPTH(16),
    .EOT_BYTE(8'h04)
  ) dut (
    .clk(clk),
    .rst(rst),
    .urx(urx),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .frame_err(frame_err),
    .overflow(overflow),
    .eot_seen(eot_seen)
  );

  int         chk = 0;
  int         pass = 0;
  logic [7:0] got[$];
  int         fe_cnt;
  int         vld_cycles;
  int         first_vld;
  int         cyc_n;
  int         stab_err;
  int         lat = 0;
  bit         rnd_rdy = 0;
  bit         prev_hold;
  logic [7:0] prev_data;

  // One cycle: drive inputs just after negedge, then observe outputs
  // that settled at the previous posedge. rdy: -1 keep/random, 0/1 set.
  task automatic cyc(input logic line, input int rdy);
    @(negedge clk);
    urx = line;
    if (rdy >= 0) rd_ready = (rdy != 0);
    else if (rnd_rdy) rd_ready = ($urandom_range(0, 1) == 1);
    if (frame_err) fe_cnt++;
    if (rd_valid) begin
      vld_cycles++;
      if (first_vld < 0) first_vld = cyc_n;
    end
    if (prev_hold && !rst && rd_data !== prev_data) stab_err++;
    prev_hold = rd_valid && !rd_ready && !rst;
    prev_data = rd_data;
    if (rd_valid && rd_ready && !rst) got.push_back(rd_data);
    cyc_n++;
  endtask

  task automatic clear_obs();
    got.delete();
    fe_cnt = 0;
    vld_cycles = 0;
    first_vld = -1;
    cyc_n = 0;
    stab_err = 0;
    prev_hold = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, -1);
  endtask

  function automatic int rsel(input int k, input int p);
    return (p < 0) ? -1 : ((k == p) ? 1 : 0);
  endfunction

  // Start bit, 8 data bits LSB first, optional low stop time, then a
  // high stop bit. pulse_k >= 0 raises rd_ready only on that cycle.
  task automatic send_frame(input logic [7:0] b, input int stop_low,
                            input int pulse_k);
    int   k;
    logic line;
    k = 0;
    for (int j = 0; j < 9; j++) begin
      line = (j == 0) ? 1'b0 : b[j-1];
      for (int c = 0; c < CPB; c++) begin
        cyc(line, rsel(k, pulse_k));
        k++;
      end
    end
    for (int c = 0; c < stop_low * CPB; c++) begin
      cyc(1'b0, rsel(k, pulse_k));
      k++;
    end
    for (int c = 0; c < CPB; c++) begin
      cyc(1'b1, rsel(k, pulse_k));
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 0);
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 0);
    chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else pass++;
    chk++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else pass++;
    chk++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else pass++;
    chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass++;
    chk++; if (eot_seen !== 1'b0) $display("FAIL reset_eot got=%b exp=0", eot_seen); else pass++;
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_single();
    clear_obs();
    rd_ready = 1'b1;
    send_frame(8'h48, 0, -1);
    idle(20);
    lat = first_vld;
    chk++; if (got.size() != 1) $display("FAIL single_count got=%0d exp=1", got.size()); else pass++;
    chk++; if ((got.size() > 0 ? got[0] : 8'hxx) !== 8'h48) $display("FAIL single_data got=%h exp=48", got.size() > 0 ? got[0] : 8'hxx); else pass++;
    chk++; if (vld_cycles != 1) $display("FAIL single_valid_cycles got=%0d exp=1", vld_cycles); else pass++;
    chk++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL single_latency got=%0d exp=%0d..%0d", lat, LAT_MIN, LAT_MAX); else pass++;
    chk++; if (fe_cnt != 0) $display("FAIL single_frame_err got=%0d exp=0", fe_cnt); else pass++;
  endtask

  task automatic test_glitch();
    clear_obs();
    rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) cyc(1'b0, -1);
    idle(400);
    chk++; if (got.size() != 0) $display("FAIL glitch_bytes got=%0d exp=0", got.size()); else pass++;
    chk++; if (fe_cnt != 0) $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); else pass++;
    send_frame(8'hC3, 0, -1);
    idle(20);
    chk++; if (got.size() != 1 || got[0] !== 8'hC3) $display("FAIL glitch_next_byte got=%0d bytes head=%h exp=1 byte C3", got.size(), got.size() > 0 ? got[0] : 8'hxx); else pass++;
  endtask

  task automatic test_frame_err();
    clear_obs();
    rd_ready = 1'b1;
    send_frame(8'h55, 3, -1);
    idle(20);
    chk++; if (fe_cnt != 1) $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); else pass++;
    chk++; if (got.size() != 0) $display("FAIL ferr_bytes got=%0d exp=0", got.size()); else pass++;
    send_frame(8'h41, 0, -1);
    idle(20);
    chk++; if (got.size() != 1 || got[0] !== 8'h41) $display("FAIL ferr_next_byte got=%0d bytes head=%h exp=1 byte 41", got.size(), got.size() > 0 ? got[0] : 8'hxx); else pass++;
    chk++; if (fe_cnt != 1) $display("FAIL ferr_after_next got=%0d exp=1", fe_cnt); else pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] mq[$];
    logic [7:0] mout[$];
    bit         movf;
    do_reset();
    clear_obs();
    movf = 0;
    rd_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 0, -1);
      if (mq.size() < 16) mq.push_back(8'(i));
      else movf = 1;
    end
    idle(5);
    chk++; if (got.size() != 0) $display("FAIL ovf_no_reads got=%0d exp=0", got.size()); else pass++;
    chk++; if (rd_valid !== 1'b1) $display("FAIL ovf_valid got=%b exp=1", rd_valid); else pass++;
    chk++; if (rd_data !== mq[0]) $display("FAIL ovf_head got=%h exp=%h", rd_data, mq[0]); else pass++;
    chk++; if (overflow !== movf) $display("FAIL ovf_flag got=%b exp=%b", overflow, movf); else pass++;
    chk++; if (stab_err != 0) $display("FAIL ovf_hold_stable got=%0d changes exp=0", stab_err); else pass++;
    // Full FIFO: pop exactly on the push cycle, so the byte is kept.
    send_frame(8'h11, 0, lat - 1);
    mout.push_back(mq.pop_front());
    mq.push_back(8'h11);
    idle(5);
    chk++; if (overflow !== movf) $display("FAIL fullpop_overflow got=%b exp=%b", overflow, movf); else pass++;
    for (int i = 0; i < 24; i++) cyc(1'b1, 1);
    while (mq.size() > 0) mout.push_back(mq.pop_front());
    chk++; if (got.size() != mout.size()) $display("FAIL drain_count got=%0d exp=%0d", got.size(), mout.size()); else pass++;
    for (int i = 0; i < mout.size(); i++) begin
      chk++; if ((i < got.size() ? got[i] : 8'hxx) !== mout[i]) $display("FAIL drain_byte%0d got=%h exp=%h", i, i < got.size() ? got[i] : 8'hxx, mout[i]); else pass++;
    end
    chk++; if (rd_valid !== 1'b0) $display("FAIL drain_empty_valid got=%b exp=0", rd_valid); else pass++;
    chk++; if (got.size() != 17) $display("FAIL empty_ready_noop got=%0d exp=17", got.size()); else pass++;
  endtask

  task automatic test_eot();
    logic [7:0] msg[3];
    msg = '{8'h68, 8'h69, EOT};
    do_reset();
    clear_obs();
    rd_ready = 1'b1;
    send_frame(msg[0], 0, -1);
    send_frame(msg[1], 0, -1);
    idle(5);
    chk++; if (eot_seen !== 1'b0) $display("FAIL eot_early got=%b exp=0", eot_seen); else pass++;
    send_frame(msg[2], 0, -1);
    idle(5);
    chk++; if (eot_seen !== 1'b1) $display("FAIL eot_set got=%b exp=1", eot_seen); else pass++;
    chk++; if (got.size() != 3) $display("FAIL eot_count got=%0d exp=3", got.size()); else pass++;
    for (int i = 0; i < 3; i++) begin
      chk++; if ((i < got.size() ? got[i] : 8'hxx) !== msg[i]) $display("FAIL eot_byte%0d got=%h exp=%h", i, i < got.size() ? got[i] : 8'hxx, msg[i]); else pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hA5;
    do_reset();
    clear_obs();
    rd_ready = 1'b0;
    send_frame(EOT, 0, -1);
    idle(5);
    chk++; if (rd_valid !== 1'b1 || eot_seen !== 1'b1) $display("FAIL rstmid_pre got=%b%b exp=11", rd_valid, eot_seen); else pass++;
    for (int j = 0; j < 5; j++) begin
      for (int c = 0; c < ((j == 4) ? CPB / 2 : CPB); c++)
        cyc((j == 0) ? 1'b0 : b[j-1], -1);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 0);
    chk++; if (rd_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", rd_valid); else pass++;
    chk++; if (rd_data !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", rd_data); else pass++;
    chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr got=%b exp=0", frame_err); else pass++;
    chk++; if (overflow !== 1'b0) $display("FAIL rstmid_ovf got=%b exp=0", overflow); else pass++;
    chk++; if (eot_seen !== 1'b0) $display("FAIL rstmid_eot got=%b exp=0", eot_seen); else pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1);
    idle(3 * CPB);
    clear_obs();
    send_frame(8'h3C, 0, -1);
    idle(20);
    chk++; if (got.size() != 1 || got[0] !== 8'h3C) $display("FAIL rstmid_next got=%0d bytes head=%h exp=1 byte 3C", got.size(), got.size() > 0 ? got[0] : 8'hxx); else pass++;
    chk++; if (fe_cnt != 0) $display("FAIL rstmid_no_ferr got=%0d exp=0", fe_cnt); else pass++;
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] b;
    bit         meot;
    do_reset();
    clear_obs();
    meot = 0;
    rnd_rdy = 1;
    for (int n = 0; n < 3; n++) begin
      b = ($urandom_range(0, 3) == 0) ? EOT : 8'($urandom_range(0, 255));
      sent.push_back(b);
      if (b == EOT) meot = 1;
      send_frame(b, 0, -1);
      idle($urandom_range(0, 200));
    end
    rnd_rdy = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, 1);
    chk++; if (got.size() != sent.size()) $display("FAIL rand_count got=%0d exp=%0d", got.size(), sent.size()); else pass++;
    for (int i = 0; i < sent.size(); i++) begin
      chk++; if ((i < got.size() ? got[i] : 8'hxx) !== sent[i]) $display("FAIL rand_byte%0d got=%h exp=%h", i, i < got.size() ? got[i] : 8'hxx, sent[i]); else pass++;
    end
    chk++; if (eot_seen !== meot) $display("FAIL rand_eot got=%b exp=%b", eot_seen, meot); else pass++;
    chk++; if (overflow !== 1'b0) $display("FAIL rand_ovf got=%b exp=0", overflow); else pass++;
    chk++; if (stab_err != 0) $display("FAIL rand_hold_stable got=%0d exp=0", stab_err); else pass++;
    chk++; if (fe_cnt != 0) $display("FAIL rand_ferr got=%0d exp=0", fe_cnt); else pass++;
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_eot();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ_MHZ, default 25, which is the clk frequency in MHz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, which is the serial bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, which is the byte FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter EOT_BYTE, default 8'h04, which is the end-of-transmission byte value.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port urx, input, 1 bit: serial line, idle high, asynchronous to clk; it connects to the SoC uart_tx.
REQ-008 The block SHALL have port rd_valid, output, 1 bit: FIFO holds at least one byte.
REQ-009 The block SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-010 The block SHALL have port rd_data, output, 8 bits: FIFO head byte.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a bad stop bit is detected.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag set when a byte is dropped because the FIFO is full.
REQ-013 The block SHALL have port eot_seen, output, 1 bit: sticky flag set when EOT_BYTE is received.

Function
REQ-014 The bit period SHALL be CPB = (CLOCK_FREQ_MHZ*1_000_000)/BAUD_RATE, truncated (217 at the defaults).
REQ-015 urx SHALL pass through a 2-flop synchronizer, reset to 1; all decoding SHALL use the synchronized value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-017 In IDLE, a synchronized 1->0 transition SHALL move the FSM to START and load the bit counter with CPB/2.
REQ-018 In START at the half-bit point: line 0 -> DATA with the counter at CPB; line 1 -> false start, return to IDLE with no byte and no error.
REQ-019 In DATA, the block SHALL sample 8 bits LSB-first, one every CPB cycles, then enter STOP.
REQ-020 In STOP at the sample point: line 1 -> push the byte and go to IDLE; line 0 -> pulse frame_err, discard the byte and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL return to IDLE only after the synchronized line is 1, so that a break never re-triggers a start.
REQ-022 A pushed byte SHALL appear at rd_data with rd_valid high on the cycle after the stop-bit sample, if the FIFO was empty.
REQ-023 rd_valid SHALL equal FIFO not-empty; a pop SHALL occur on rd_valid && rd_ready; rd_data SHALL stay stable while rd_valid && !rd_ready.
REQ-024 A push while full without a same-cycle pop SHALL drop the byte and set overflow.
REQ-025 A push while full with a same-cycle pop SHALL accept the byte and leave overflow unchanged.
REQ-026 A simultaneous push and pop at any occupancy SHALL keep the count unchanged.
REQ-027 The FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and SHALL wrap naturally; full/empty SHALL be derived from the pointer MSB and the remaining bits.
REQ-028 eot_seen SHALL set on any valid-stop byte equal to EOT_BYTE, including a byte that overflow drops.
REQ-029 rd_ready high while the FIFO is empty SHALL have no effect.

Reset
REQ-030 On rst the block SHALL set: FSM to IDLE, synchronizer to 1, FIFO empty, rd_valid=0, rd_data=0, frame_err=0, overflow=0, eot_seen=0.
REQ-031 rst asserted mid-frame SHALL abandon the frame; after release, decoding SHALL begin at the next falling edge only.

Configuration
REQ-032 With UART_RX_MONITOR_PRINT_EN defined, each pushed byte SHALL be written to the simulator console as a character at push time, and frame_err and overflow events SHALL each print a one-line message.
REQ-033 Without UART_RX_MONITOR_PRINT_EN, the block SHALL have no console output and SHALL be fully synthesizable.
REQ-034 Port behaviour SHALL be identical with and without UART_RX_MONITOR_PRINT_EN.

Verification
REQ-035 Drive 0x48 at 115200 baud with rd_ready=1: rd_data=0x48 and rd_valid is high for 1 cycle, 1 cycle after the stop-bit sample; frame_err=0.
REQ-036 Drive a 100-cycle low glitch: no byte, no frame_err, and the FSM is back in IDLE.
REQ-037 Drive 0x55 with the stop bit held low for 3 bit times: frame_err pulses once, no byte, and the next byte 0x41 is received correctly.
REQ-038 With rd_ready=0, send 17 bytes 0x00..0x10: 16 bytes are held, overflow=1, and draining yields 0x00..0x0F in order.
REQ-039 Send "hi" then 0x04: the bytes 0x68, 0x69 and 0x04 are read and eot_seen=1 after the third stop bit.
REQ-040 Assert rst during data bit 4 of 0xA5, release, then send 0x3C: only 0x3C is received, and all outputs read their reset values during rst.
